// File: rtl/mmio_seg7_ctrl.sv
// Memory-mapped seven-segment controller: DATA/CTRL registers on the CPU data bus,
// driving hex digits either statically in parallel or time-multiplexed with an anti-ghost gap.
module mmio_seg7_ctrl #(
  parameter logic [31:0] BASE_ADR       = 32'h8000_0000,
  parameter int          NUM_DIGITS     = 8,
  parameter int          SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             mem_adr,
  input  logic [31:0]             mem_wdata,
  input  logic                    mem_wen,
  input  logic [3:0]              mem_wstrb,
  input  logic                    mem_ren,
  output logic [31:0]             mem_rdata,
  output logic                    mem_rvalid,
  output logic [7*NUM_DIGITS-1:0] seg_static,
  output logic [6:0]              seg_mux,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {SLOT, GAP} scan_state_t;

  logic [31:0]           data_q, data_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [31:0]           rdata_q;
  logic                  rvalid_q;
  scan_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [6:0]            seg_mux_q;
  logic [NUM_DIGITS-1:0] dig_sel_q;

  logic                  hit_data, hit_ctrl, restart, scanning, nz;
  logic [31:0]           rd_mux;
  logic [6:0]            code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign hit_data = (mem_adr == BASE_ADR);
  assign hit_ctrl = (mem_adr == BASE_ADR + 32'd4);
  assign scanning = ctrl_q[0] & ctrl_q[2];

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (mem_wen && hit_data) begin
      for (int k = 0; k < 4; k++)
        if (mem_wstrb[k]) data_d[8*k +: 8] = mem_wdata[8*k +: 8];
    end
    if (mem_wen && hit_ctrl && mem_wstrb[0]) ctrl_d = mem_wdata[2:0];
  end

  // A mode flip or disable restarts the scan sequence from digit 0.
  assign restart = mem_wen && hit_ctrl && mem_wstrb[0] &&
                   ((ctrl_d[2] != ctrl_q[2]) || !ctrl_d[0]);

  always_comb begin
    if (hit_data)      rd_mux = data_q;
    else if (hit_ctrl) rd_mux = {29'd0, ctrl_q};
    else               rd_mux = 32'd0;
  end

  // Scan from the top nibble down so nz tells whether any digit at or above i is nonzero.
  always_comb begin
    nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz = nz | (|data_q[4*i +: 4]);
      code[i] = (ctrl_q[0] && (!ctrl_q[1] || nz || i == 0)) ? hex7(data_q[4*i +: 4]) : 7'h00;
    end
  end

  assign onehot = NUM_DIGITS'(1) << idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      state_q   <= SLOT;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_mux_q <= '0;
      dig_sel_q <= '0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      rvalid_q <= mem_ren;
      if (mem_ren) rdata_q <= rd_mux;

      if (scanning && state_q == SLOT) begin
        dig_sel_q <= onehot;
        seg_mux_q <= code[idx_q];
      end else begin
        dig_sel_q <= '0;
        seg_mux_q <= '0;
      end

      if (restart || !scanning) begin
        state_q <= SLOT;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else begin
        case (state_q)
          SLOT: begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) state_q <= GAP;
            else                               cnt_q   <= cnt_q + CNT_W'(1);
          end
          default: begin
            idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            cnt_q   <= '0;
            state_q <= SLOT;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_static
    assign seg_static[7*i +: 7] = (ctrl_q[2] ? 7'h00 : code[i]) ^ {7{SEG_ACTIVE_LOW}};
  end

  assign seg_mux    = seg_mux_q ^ {7{SEG_ACTIVE_LOW}};
  assign dig_sel    = dig_sel_q ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;

endmodule

// File: tb/tb_mmio_seg7_ctrl.sv
// Directed bench for mmio_seg7_ctrl: static decode, strobes, blanking, scan timing,
// read/write collision and asynchronous reset, all against hand-computed values.
module tb_mmio_seg7_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int ND = 8;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_adr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_wen = 1'b0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ren = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [7*ND-1:0] seg_static;
  logic [6:0]  seg_mux;
  logic [ND-1:0] dig_sel;

  int checks = 0;
  int failures = 0;

  // Active-low codes for digits 0..7 of 0x1234ABCD: D C B A 4 3 2 1
  logic [6:0] dcode [ND] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

  mmio_seg7_ctrl #(.BASE_ADR(BASE), .NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_wstrb(mem_wstrb), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .seg_static(seg_static), .seg_mux(seg_mux), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] strb);
    @(negedge clk);
    mem_adr = adr; mem_wdata = d; mem_wstrb = strb; mem_wen = 1'b1;
    @(negedge clk);
    mem_wen = 1'b0; mem_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    check({tag, "_rvalid_idle"}, 64'(mem_rvalid), 64'd0);
    mem_adr = adr; mem_ren = 1'b1;
    @(negedge clk);
    mem_ren = 1'b0;
    check({tag, "_rvalid"}, 64'(mem_rvalid), 64'd1);
    check({tag, "_rdata"}, 64'(mem_rdata), 64'(exp));
  endtask

  initial begin
    logic [ND-1:0] exp_sel;
    logic [6:0]    exp_mux;
    bit            found;

    // Reset state
    #12;
    check("rst_static", 64'(seg_static), 64'h00FF_FFFF_FFFF_FFFF);
    check("rst_mux", 64'(seg_mux), 64'h7F);
    check("rst_sel", 64'(dig_sel), 64'hFF);
    check("rst_rvalid", 64'(mem_rvalid), 64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Static display
    wr(BASE, 32'h1234_ABCD, 4'hF);
    wr(BASE + 4, 32'h1, 4'hF);
    check("st_d0", 64'(seg_static[6:0]), 64'h21);
    check("st_d1", 64'(seg_static[13:7]), 64'h46);
    check("st_d3", 64'(seg_static[27:21]), 64'h08);
    check("st_d4", 64'(seg_static[34:28]), 64'h19);
    check("st_d7", 64'(seg_static[55:49]), 64'h79);
    check("st_mux", 64'(seg_mux), 64'h7F);
    check("st_sel", 64'(dig_sel), 64'hFF);
    rd(BASE, 32'h1234_ABCD, "rd_data");
    rd(BASE + 4, 32'h1, "rd_ctrl");
    wr(BASE + 4, 32'hFFFF_FFF1, 4'hF);
    rd(BASE + 4, 32'h1, "rd_ctrl_hi_ignored");

    // Byte strobe
    wr(BASE, 32'hFFFF_FFFF, 4'b0010);
    rd(BASE, 32'h1234_FFCD, "strobe");

    // Leading-zero blanking
    wr(BASE, 32'h0000_00A0, 4'hF);
    wr(BASE + 4, 32'h3, 4'hF);
    check("lzb_hi_dark", 64'(seg_static[55:14]), 64'h3FF_FFFF_FFFF);
    check("lzb_d1", 64'(seg_static[13:7]), 64'h08);
    check("lzb_d0", 64'(seg_static[6:0]), 64'h40);
    wr(BASE, 32'h0, 4'hF);
    check("lzb0_hi_dark", 64'(seg_static[55:7]), 64'h1_FFFF_FFFF_FFFF);
    check("lzb0_d0", 64'(seg_static[6:0]), 64'h40);
    wr(BASE + 4, 32'h0, 4'hF);
    check("en_off_dark", 64'(seg_static), 64'h00FF_FFFF_FFFF_FFFF);

    // Scan: 4 lit cycles then 1 dark gap per digit, 40-cycle frame
    wr(BASE, 32'h1234_ABCD, 4'hF);
    wr(BASE + 4, 32'h5, 4'hF);
    check("scan_static_dark", 64'(seg_static), 64'h00FF_FFFF_FFFF_FFFF);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (((c - 1) % 5) < 4) begin
        exp_sel = ~(8'h01 << (((c - 1) / 5) % ND));
        exp_mux = dcode[((c - 1) / 5) % ND];
      end else begin
        exp_sel = 8'hFF;
        exp_mux = 7'h7F;
      end
      check($sformatf("scan_sel_c%0d", c), 64'(dig_sel), 64'(exp_sel));
      check($sformatf("scan_mux_c%0d", c), 64'(seg_mux), 64'(exp_mux));
    end

    // Read/write collision and unmapped read
    wr(BASE + 4, 32'h1, 4'hF);
    wr(BASE, 32'h11, 4'hF);
    @(negedge clk);
    mem_adr = BASE; mem_wdata = 32'h55; mem_wstrb = 4'hF; mem_wen = 1'b1; mem_ren = 1'b1;
    @(negedge clk);
    mem_wen = 1'b0; mem_ren = 1'b0; mem_wstrb = '0;
    check("coll_rvalid", 64'(mem_rvalid), 64'd1);
    check("coll_old", 64'(mem_rdata), 64'h11);
    rd(BASE, 32'h55, "coll_new");
    rd(BASE + 8, 32'h0, "unmapped");

    // Async reset mid-scan at digit 3 with a read in flight
    wr(BASE, 32'h1234_ABCD, 4'hF);
    wr(BASE + 4, 32'h5, 4'hF);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (dig_sel == 8'hF7) found = 1'b1;
    end
    check("scan_reach_d3", 64'(found), 64'd1);
    mem_adr = BASE; mem_ren = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_rvalid", 64'(mem_rvalid), 64'd1);
    rst_n = 1'b0;
    mem_ren = 1'b0;
    #1;
    check("arst_sel", 64'(dig_sel), 64'hFF);
    check("arst_mux", 64'(seg_mux), 64'h7F);
    check("arst_static", 64'(seg_static), 64'h00FF_FFFF_FFFF_FFFF);
    check("arst_rvalid", 64'(mem_rvalid), 64'd0);
    check("arst_rdata", 64'(mem_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(BASE + 4, 32'h0, "post_rst_ctrl");
    rd(BASE, 32'h0, "post_rst_data");
    check("post_rst_static", 64'(seg_static), 64'h00FF_FFFF_FFFF_FFFF);
    check("post_rst_sel", 64'(dig_sel), 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_seg7_ctrl.md
Name: mmio_seg7_ctrl

Overview:
Memory-mapped seven-segment display controller on the CPU data-memory bus. Decodes writes to a small register window (data, control) with byte strobes, supports readback, and drives NUM_DIGITS hex digits in either static mode (all digits driven in parallel) or time-multiplexed scan mode (one shared segment bus plus one-hot digit select). Adds leading-zero blanking and a global enable.

Parameters:
BASE_ADR, 32'h8000_0000, byte address of DATA register; CTRL at BASE_ADR+4; BASE_ADR[2:0] must be 0
NUM_DIGITS, 8, displayed nibbles, 1..8; digit i shows DATA[4i+3:4i]
SCAN_DIV, 1000, clk cycles per digit slot in scan mode, >= 2
SEG_ACTIVE_LOW, 1, 1: segment and digit-select outputs active-low; 0: active-high

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_adr  in  32  byte address from CPU store/load path
mem_wdata  in  32  write data
mem_wen  in  1  write strobe, one cycle per store
mem_wstrb  in  4  byte enables, bit k -> wdata[8k+7:8k]
mem_ren  in  1  read strobe
mem_rdata  out  32  read data, valid one cycle after mem_ren
mem_rvalid  out  1  pulses with mem_rdata
seg_static  out  7*NUM_DIGITS  digit i at [7i+6:7i], encoding g..a (bit6=g, bit0=a)
seg_mux  out  7  shared segment bus, scan mode
dig_sel  out  NUM_DIGITS  one-hot digit enable, scan mode

Behaviour:
- Reset (rst_n low, async): DATA=0, CTRL=0, scan counter=0, digit index=0, mem_rdata=0, mem_rvalid=0. Outputs then show all-dark: every segment and dig_sel bit at inactive level (1 if SEG_ACTIVE_LOW).
- Address decode: hit_data = mem_adr==BASE_ADR; hit_ctrl = mem_adr==BASE_ADR+4. Other addresses ignored (no write, read returns 0 with rvalid still pulsed).
- Write: on clk with mem_wen and hit, each byte with strobe set updated; unstrobed bytes keep value. New value visible on outputs next cycle.
- CTRL bits: [0] EN, [1] LZB (leading-zero blanking), [2] SCAN (0 static, 1 multiplexed). Bits [31:3] read as 0, writes ignored.
- Read: mem_ren and hit -> mem_rdata registered, 1-cycle latency, mem_rvalid high exactly that cycle. Simultaneous mem_wen and mem_ren to same register: read returns OLD value; write takes effect.
- Hex encoding (a..g lit): 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F,A 77,B 7C,C 39,D 5E,E 79,F 71. Output inverted when SEG_ACTIVE_LOW.
- Blanking: digit i blank if EN=0, or LZB=1 and all nibbles i..NUM_DIGITS-1 are 0 and i!=0 (digit 0 always shown when EN=1). Blank = all segments inactive.
- Static mode (SCAN=0): seg_static per digit; seg_mux inactive; dig_sel all inactive. seg_static is combinational from registers.
- Scan mode (SCAN=1): seg_static all inactive. States SLOT, GAP. SLOT: dig_sel active only at bit idx, seg_mux = digit idx code; counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 -> GAP. GAP (exactly 1 cycle, anti-ghosting): dig_sel and seg_mux all inactive; idx <= idx==NUM_DIGITS-1 ? 0 : idx+1; counter <= 0; -> SLOT. Full frame = NUM_DIGITS*(SCAN_DIV+1) cycles.
- seg_mux/dig_sel registered (1-cycle lag from counter state); data change mid-slot appears next cycle.
- Writing SCAN 1->0 or 0->1, or EN=0: counter, idx, state reset to 0/SLOT on next edge.
- rst_n asserted mid-slot or mid-read: immediate return to reset values; pending rvalid dropped.

Test Plan:
Reset, then static: write 0x1234_ABCD to BASE_ADR strobe F, CTRL=0x1 -> seg_static digit0=~0x5E, digit7=~0x06; read DATA -> rdata 0x1234ABCD, rvalid one cycle after ren.
Byte strobe: DATA=0x1234ABCD, write 0xFFFF_FFFF strobe 4'b0010 -> read 0x1234FFCD.
LZB: DATA=0x0000_00A0, CTRL=0x3 -> digits 2..7 dark, digit1=~0x77, digit0=~0x3F; DATA=0 -> only digit0 lit (~0x3F).
Scan, SCAN_DIV=4, NUM_DIGITS=8: CTRL=0x5 -> dig_sel=~8'h01 for 4 cycles, 1 all-dark cycle, then ~8'h02; after digit7 wraps to ~8'h01; frame 40 cycles.
Collision: same-cycle write 0x55 and read of DATA (old 0x11) -> rdata 0x11, next read 0x55; read of BASE_ADR+8 -> rdata 0, rvalid 1.
Async reset mid-scan at digit 3 -> outputs all inactive immediately, CTRL=0, after release static/dark.
